// File: rtl/dmem_mmio_if.sv
// Data-memory port between the pipeline M stage (master) and the memory responder (slave).
interface dmem_mmio_if;
    logic        we;
    logic        sb;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output sb, output addr, output wd, input rd);
    modport slave  (input we, input sb, input addr, input wd, output rd);
endinterface

// File: rtl/dmem_mmio.sv
// Data memory for the M stage: word-addressed RAM with byte stores plus a small
// I/O window holding a free-running cycle counter, a GPIO register and sticky error flags.
module dmem_mmio #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus,
    output logic [31:0] gpio_out,
    output logic [1:0]  err
);
    localparam int IDXW = $clog2(DEPTH);

    logic [31:0]     mem [DEPTH];
    logic [31:0]     cycleCount;
    logic [31:0]     readData;
    logic            ioSel;
    logic [1:0]      ioOffset;
    logic [IDXW-1:0] ramIndex;
    logic            wordStore;
    logic            byteStore;
    logic            ioWordStore;
    logic [1:0]      errSet;
    logic [1:0]      errClear;

    assign ioSel       = (bus.addr[31:4] == MMIO_BASE[31:4]);
    assign ioOffset    = bus.addr[3:2];
    assign ramIndex    = bus.addr[IDXW+1:2];
    assign wordStore   = bus.we & ~bus.sb;
    assign byteStore   = bus.we & bus.sb;
    assign ioWordStore = ioSel & wordStore;

    // Misaligned stores are flagged but still performed; byte stores never reach I/O registers.
    assign errSet   = {byteStore & ioSel, wordStore & (bus.addr[1:0] != 2'b00)};
    assign errClear = (ioWordStore && ioOffset == 2'd2) ? bus.wd[1:0] : 2'b00;

    always_comb begin
        readData = '0;
        if (ioSel) begin
            case (ioOffset)
                2'd0:    readData = cycleCount;
                2'd1:    readData = gpio_out;
                2'd2:    readData = {30'b0, err};
                default: readData = '0;
            endcase
        end else begin
            readData = mem[ramIndex];
        end
    end

    assign bus.rd = readData;

    // A store to CYCLE wins over the increment; a newly raised error wins over its clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
            gpio_out   <= '0;
            err        <= '0;
        end else begin
            if (ioWordStore && ioOffset == 2'd0) begin
                cycleCount <= bus.wd;
            end else begin
                cycleCount <= cycleCount + 32'd1;
            end
            if (ioWordStore && ioOffset == 2'd1) begin
                gpio_out <= bus.wd;
            end
            err <= (err & ~errClear) | errSet;
        end
    end

    // RAM has no reset value; reset only suppresses a store issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset && !ioSel && bus.we) begin
            if (!bus.sb) begin
                mem[ramIndex] <= bus.wd;
            end else begin
                case (bus.addr[1:0])
                    2'd0:    mem[ramIndex][7:0]   <= bus.wd[7:0];
                    2'd1:    mem[ramIndex][15:8]  <= bus.wd[7:0];
                    2'd2:    mem[ramIndex][23:16] <= bus.wd[7:0];
                    default: mem[ramIndex][31:24] <= bus.wd[7:0];
                endcase
            end
        end
    end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory responder for the M stage of the pipelined MIPS core. It is the memory end of the core's data-memory port: address = aluoutM, write data = writedataM, read data returned on readdataM.
- Contains a word-addressed RAM with word and byte (sb) stores.
- Contains a small memory-mapped I/O window: free-running cycle counter, GPIO output register, sticky error/status register.
- Read data is combinational from the address so the core registers it into W on the next edge; all state updates occur on the rising clock edge.

Parameters:
- DEPTH, 64, number of 32-bit RAM words (power of two).
- MMIO_BASE, 32'hFFFF_0000, base address of the I/O window; addr[31:4] == MMIO_BASE[31:4] selects I/O.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  store enable (memwriteM).
- sb  in  1  byte store qualifier; valid only with we.
- addr  in  32  byte address (aluoutM).
- wd  in  32  store data (writedataM); byte stores use wd[7:0].
- rd  out  32  read data (readdataM), combinational.
- gpio_out  out  32  GPIO output register.
- err  out  2  sticky error flags: bit0 misaligned word access, bit1 byte store to I/O.

Behaviour:
- Decode: io_sel = (addr[31:4] == MMIO_BASE[31:4]). Otherwise RAM is selected, with index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so the RAM aliases modulo DEPTH words.
- RAM word store (we=1, sb=0): mem[index] <= wd at the edge.
- RAM byte store (we=1, sb=1): only lane addr[1:0] is written; lane 0 = bits 7:0 … lane 3 = bits 31:24; other lanes are unchanged.
- RAM read: rd = mem[index], full word, same cycle. Byte selection and sign extension are done downstream, not here.
- Read-during-write to the same word: rd shows the old contents; the new value is visible from the next cycle.
- RAM is not cleared by reset; its contents are undefined until written.
- I/O map, by offset addr[3:2]:
  - 0 CYCLE: rw, 32-bit counter.
  - 1 GPIO: rw.
  - 2 STATUS: rd = {30'b0, err}; write-1-to-clear.
  - 3: reserved, reads 0, writes ignored.
- CYCLE:
  - Increments by 1 every cycle; wraps FFFF_FFFF -> 0.
  - A word store loads wd; load has priority over increment that cycle, so the next cycle reads wd and the cycle after reads wd+1.
- GPIO: a word store loads wd; gpio_out = register.
- STATUS write: err <= err & ~wd[1:0].
- Errors:
  - Word store (we=1, sb=0) with addr[1:0] != 0 sets err[0].
  - Stores are never gated: a misaligned RAM store still writes mem[index] and a misaligned I/O store still takes effect.
  - A byte store to the I/O window sets err[1] and does not modify any I/O register.
  - Reads never set errors.
  - Set has priority over a simultaneous clear of the same bit.
- Reset (reset=1 at the edge): CYCLE=0, gpio_out=0, err=0, RAM untouched. Reset overrides any store in the same cycle. The first edge after reset release is the first increment, so CYCLE reads 1 in the following cycle.
- we=0: no state change except the CYCLE increment.
- Latency: read 0 cycles (combinational), write 1 edge.

Test Plan:
- Word store/readback: we=1, addr=0x10, wd=0xDEADBEEF, one cycle -> next cycle addr=0x10 gives rd=0xDEADBEEF; addr=0x10+4*DEPTH aliases and also returns 0xDEADBEEF.
- Byte lanes: after the word 0x11223344 is at 0x20, sb to 0x21 with wd=0x000000AA -> rd=0x1122AA44. Then sb to 0x23 with wd=0x55 -> rd=0x5522AA44. err stays 0.
- Counter:
  - Reset held 2 cycles, then released -> CYCLE reads 0 in the first post-reset cycle, then 1, 2, 3 in consecutive cycles.
  - Store 0xFFFFFFFE to 0xFFFF0000 -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the following cycles.
- GPIO and reset priority: store 0xA5A5A5A5 to 0xFFFF0004 -> gpio_out=0xA5A5A5A5. A store of 0x1 with reset=1 in the same cycle -> gpio_out=0.
- Errors:
  - Word store to 0x32 -> err=01 and mem[12] updated.
  - sb to 0xFFFF0004 -> err=11 and gpio_out unchanged.
  - Store 0x1 to 0xFFFF0008 -> err=10. Store 0x2 -> err=00.
  - Misaligned store in the same cycle as a clear of bit0 -> err[0] stays 1.
- Read-during-write: store 0x12345678 to 0x40 (old value 0x0) while sampling rd in the same cycle -> rd=0x0 that cycle and 0x12345678 the next.
